// File: rtl/matmul_pkg.sv
// matmul_pkg: definitions shared between the matrix multiplier and its
// result serializer.
//   MATMUL_OUTPUT_WIDTH : default width of one result lane
//   MATMUL_MAC_NUM      : default number of lanes per result word
//   state_e             : IDLE/SEND encodings of the serializer FSM
package matmul_pkg;

  localparam int unsigned MATMUL_OUTPUT_WIDTH = 8;
  localparam int unsigned MATMUL_MAC_NUM      = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/matmul_result_serializer_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset (empties the FIFO)
//   wr_en   : write request; accepted when not full, or when full and a
//             read is performed on the same edge
//   wr_data : word to write
//   rd_en   : read request; ignored while empty
//   rd_data : head word, valid whenever empty is low
//   full    : DEPTH words stored (combinational from the count)
//   empty   : no words stored
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      w_count;
  logic             w_wr_fire;
  logic             w_rd_fire;

  // Pointers carry one extra wrap bit so the difference is the occupancy.
  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign full      = (w_count == (AW+1)'(DEPTH));
  assign empty     = (w_count == '0);
  assign w_rd_fire = rd_en && !empty;
  // A same-edge read frees the slot the write needs.
  assign w_wr_fire = wr_en && (!full || w_rd_fire);
  assign rd_data   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_fire) begin
        r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_rd_fire) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/matmul_result_serializer.sv
// matmul_result_serializer: buffers packed result words from the matrix
// multiplier and streams them out one lane per beat (valid/ready).
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset
//   done_i     : one-cycle strobe, matmul_i valid
//   matmul_i   : packed result word, lane 0 in the MSBs
//   m_valid_o  : serial output valid
//   m_ready_i  : downstream ready
//   m_data_o   : current lane value
//   m_lane_o   : index of current lane
//   m_last_o   : high with lane MAC_NUM-1
//   full_o     : FIFO holds FIFO_DEPTH words
//   overflow_o : sticky, a done_i word was dropped
module matmul_result_serializer
  import matmul_pkg::*;
#(
  parameter int unsigned OUTPUT_WIDTH = MATMUL_OUTPUT_WIDTH,
  parameter int unsigned MAC_NUM      = MATMUL_MAC_NUM,
  parameter int unsigned FIFO_DEPTH   = 4,
  localparam int unsigned WORD_W      = OUTPUT_WIDTH * MAC_NUM,
  localparam int unsigned LANE_W      = (MAC_NUM > 1) ? $clog2(MAC_NUM) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    done_i,
  input  logic [WORD_W-1:0]       matmul_i,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [OUTPUT_WIDTH-1:0] m_data_o,
  output logic [LANE_W-1:0]       m_lane_o,
  output logic                    m_last_o,
  output logic                    full_o,
  output logic                    overflow_o
);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [WORD_W-1:0]       r_hold;
  logic [LANE_W-1:0]       r_lane;
  logic                    r_overflow;
  logic [WORD_W-1:0]       w_fifo_head;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic                    w_pop;
  logic                    w_advance;
  logic                    w_is_last;
  logic [OUTPUT_WIDTH-1:0] w_lane_data;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_en   (done_i),
    .wr_data (matmul_i),
    .rd_en   (w_pop),
    .rd_data (w_fifo_head),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty)
  );

  assign w_is_last = (r_lane == LANE_W'(MAC_NUM - 1));

  // Lane select is a mux over the hold register; lane 0 sits in the MSBs.
  always_comb begin
    w_lane_data = '0;
    for (int unsigned i = 0; i < MAC_NUM; i++) begin
      if (r_lane == LANE_W'(i)) begin
        w_lane_data = r_hold[OUTPUT_WIDTH*(MAC_NUM-1-i) +: OUTPUT_WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_advance   = 1'b0;
    m_valid_o   = 1'b0;
    m_data_o    = '0;
    m_lane_o    = '0;
    m_last_o    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        m_valid_o = 1'b1;
        m_data_o  = w_lane_data;
        m_lane_o  = r_lane;
        m_last_o  = w_is_last;
        if (m_ready_i) begin
          if (w_is_last) begin
            // Reload straight from the FIFO so consecutive words have no bubble.
            if (!w_fifo_empty) begin
              w_pop = 1'b1;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hold <= '0;
      r_lane <= '0;
    end else if (w_pop) begin
      r_hold <= w_fifo_head;
      r_lane <= '0;
    end else if (w_advance) begin
      r_lane <= r_lane + LANE_W'(1);
    end
  end

  // Dropped only when full and no pop frees a slot on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_overflow <= 1'b0;
    end else if (done_i && w_fifo_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  assign full_o     = w_fifo_full;
  assign overflow_o = r_overflow;

endmodule

// File: tb/tb_matmul_result_serializer.sv
// Testbench for matmul_result_serializer (default parameters).
module tb_matmul_result_serializer;

  localparam int M = 8;
  localparam int D = 4;
  localparam logic [63:0] WORD = 64'h0102030405060708;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        done = 1'b0;
  logic [63:0] din = '0;
  logic        rdy = 1'b0;
  logic        valid, last, full, ovf;
  logic [7:0]  data;
  logic [2:0]  lane;

  always #5 clk = ~clk;

  matmul_result_serializer #(
    .OUTPUT_WIDTH (8),
    .MAC_NUM      (8),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .done_i     (done),
    .matmul_i   (din),
    .m_valid_o  (valid),
    .m_ready_i  (rdy),
    .m_data_o   (data),
    .m_lane_o   (lane),
    .m_last_o   (last),
    .full_o     (full),
    .overflow_o (ovf)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: queue of stored words plus the word being sent.
  logic [63:0] mq[$];
  logic [63:0] m_cur;
  int          m_lane;
  bit          m_busy;
  bit          m_ovf;
  bit          m_known = 0;

  function automatic logic [7:0] lane_of(logic [63:0] w, int l);
    return w[63-8*l -: 8];
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Compare current outputs with the model, drive inputs, advance one edge.
  task automatic cycle(input bit r, input bit d, input logic [63:0] w, input bit rd);
    bit xfer, lastx, pop;
    if (m_known) begin
      check("valid", valid, m_busy);
      check("data", data, m_busy ? lane_of(m_cur, m_lane) : 8'h0);
      check("lane", lane, m_busy ? m_lane : 0);
      check("last", last, m_busy && m_lane == M-1);
      check("full", full, mq.size() == D);
      check("overflow", ovf, m_ovf);
    end
    rst = r; done = d; din = w; rdy = rd;
    xfer  = m_busy && rd;
    lastx = xfer && m_lane == M-1;
    pop   = mq.size() > 0 && (!m_busy || lastx);
    if (r) begin
      mq.delete(); m_busy = 0; m_lane = 0; m_ovf = 0; m_known = 1;
    end else begin
      if (pop) begin m_cur = mq.pop_front(); m_lane = 0; m_busy = 1; end
      else if (lastx) m_busy = 0;
      else if (xfer) m_lane++;
      if (d) begin
        if (mq.size() < D) mq.push_back(w);
        else m_ovf = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          rst;
    bit          done;
    logic [63:0] din;
    bit          rdy;
    bit          e_valid;
    logic [7:0]  e_data;
    logic [2:0]  e_lane;
    bit          e_last;
  } vec_t;

  vec_t        vecs[11];
  int          got;
  bit          stalled;
  logic [7:0]  prev_d;
  logic [2:0]  prev_l;
  logic [63:0] wa, wb, wnew;
  logic [7:0]  last_beat;
  int          nvalid;

  initial begin
    vecs[0] = '{1, 0, 64'h0, 1, 0, 8'h0, 3'h0, 0};
    vecs[1] = '{0, 1, WORD, 1, 0, 8'h0, 3'h0, 0};
    for (int i = 0; i < 8; i++)
      vecs[i+2] = '{0, 0, 64'h0, 1, 1, 8'(i+1), 3'(i), (i == 7)};
    vecs[10] = '{0, 0, 64'h0, 1, 0, 8'h0, 3'h0, 0};

    // Single word, full-rate drain
    for (int i = 0; i < 11; i++) begin
      cycle(vecs[i].rst, vecs[i].done, vecs[i].din, vecs[i].rdy);
      check($sformatf("vec%0d_valid", i), valid, vecs[i].e_valid);
      check($sformatf("vec%0d_data", i), data, vecs[i].e_data);
      check($sformatf("vec%0d_lane", i), lane, vecs[i].e_lane);
      check($sformatf("vec%0d_last", i), last, vecs[i].e_last);
    end

    // Back-pressure: ready low on alternate cycles
    cycle(1, 0, 0, 1);
    cycle(0, 1, WORD, 0);
    got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      bit r;
      r = (c % 2) == 1;
      if (valid && r) begin
        check("bp_order", data, lane_of(WORD, got));
        got++;
      end
      stalled = valid && !r;
      prev_d = data; prev_l = lane;
      cycle(0, 0, 0, r);
      if (stalled) begin
        check("bp_hold_data", data, prev_d);
        check("bp_hold_lane", lane, prev_l);
        check("bp_hold_valid", valid, 1);
      end
    end
    check("bp_count", got, 8);

    // Back-to-back words with no gap
    wa = 64'hA0A1A2A3A4A5A6A7;
    wb = 64'hB0B1B2B3B4B5B6B7;
    cycle(1, 0, 0, 1);
    cycle(0, 1, wa, 1);
    cycle(0, 1, wb, 1);
    for (int i = 0; i < 16; i++) begin
      check("b2b_valid", valid, 1);
      check("b2b_data", data, i < 8 ? lane_of(wa, i) : lane_of(wb, i-8));
      cycle(0, 0, 0, 1);
    end
    check("b2b_end_idle", valid, 0);

    // Overflow: 6 strobes with ready low
    cycle(1, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      cycle(0, 1, 64'h1111111111111111 * (k+1), 0);
      if (k == 3) check("ovf_full_after4", full, 0);
      if (k == 4) check("ovf_full_after5", full, 1);
      if (k <= 4) check("ovf_not_yet", ovf, 0);
    end
    check("ovf_set", ovf, 1);
    check("ovf_full_kept", full, 1);
    for (int i = 0; i < 50; i++) cycle(0, 0, 0, 1);
    check("ovf_sticky", ovf, 1);
    check("ovf_drained", valid, 0);
    cycle(1, 0, 0, 1);
    check("ovf_reset_clears", ovf, 0);

    // Full FIFO, last-lane transfer on the same edge as done
    wnew = 64'hC0C1C2C3C4C5C6C7;
    for (int k = 0; k < 5; k++) cycle(0, 1, 64'h0101010101010101 * (k+3), 0);
    check("sp_full", full, 1);
    for (int c = 0; c < 20 && !(valid && lane == 3'd7); c++) cycle(0, 0, 0, 1);
    check("sp_reach_lane7", lane, 7);
    cycle(0, 1, wnew, 1);
    check("sp_no_overflow", ovf, 0);
    check("sp_still_full", full, 1);
    check("sp_next_lane0", lane, 0);
    got = 0; last_beat = '0;
    for (int c = 0; c < 60; c++) begin
      if (valid) begin got++; last_beat = data; end
      cycle(0, 0, 0, 1);
    end
    check("sp_beats", got, 40);
    check("sp_last_beat_new", last_beat, lane_of(wnew, 7));
    check("sp_ovf_final", ovf, 0);

    // Reset mid-word, with a second word queued
    cycle(1, 0, 0, 1);
    cycle(0, 1, wa, 1);
    cycle(0, 1, wb, 1);
    for (int c = 0; c < 20 && lane != 3'd4; c++) cycle(0, 0, 0, 1);
    check("rm_at_lane4", lane, 4);
    cycle(1, 1, wnew, 1);
    check("rm_valid0", valid, 0);
    check("rm_data0", data, 0);
    check("rm_lane0", lane, 0);
    check("rm_last0", last, 0);
    check("rm_full0", full, 0);
    check("rm_ovf0", ovf, 0);
    nvalid = 0;
    for (int c = 0; c < 20; c++) begin
      if (valid) nvalid++;
      cycle(0, 0, 0, 1);
    end
    check("rm_no_stale", nvalid, 0);

    // Randomized traffic against the model
    cycle(1, 0, 0, 1);
    for (int c = 0; c < 600; c++) begin
      bit d, r;
      d = $urandom_range(0, 2) == 0;
      r = (c / 40) % 2 == 0 ? $urandom_range(0, 3) != 0 : $urandom_range(0, 3) == 0;
      cycle(0, d, {$urandom, $urandom}, r);
    end
    for (int c = 0; c < 60; c++) cycle(0, 0, 0, 1);
    check("rand_drained", valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
